// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle signed MULT/DIV unit for the multicycle MIPS datapath.
//   A start pulse in IDLE captures a/b/op. The unit then runs one radix-2
//   step per cycle for WIDTH cycles, either a Booth multiply or a restoring
//   divide on magnitudes. One FIX cycle applies the sign correction and
//   latches hi/lo. One DONE cycle then pulses done/load_hi/load_lo.
//   DIV by zero takes a single DZ cycle that pulses div_zero and leaves
//   hi/lo untouched.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   start      one-cycle request, honoured only in IDLE
//   op         0 = MULT (signed), 1 = DIV (signed), sampled with start
//   a, b       multiplicand/dividend, multiplier/divisor
//   busy       high whenever the unit is not IDLE
//   done       one-cycle pulse in DONE
//   div_zero   one-cycle pulse in DZ
//   load_hi    Hi register load strobe (same cycle as done)
//   load_lo    Lo register load strobe (same cycle as done)
//   hi, lo     MULT: product high/low word; DIV: remainder/quotient
//   state_dbg  current FSM state, for observation only
//
// Handshake: start is a request with no ready. It is accepted only when
// busy is low. Anything on start/a/b/op while busy is high is ignored.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             load_hi,
    output logic             load_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_FIX  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_DZ   = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic             op_r;
    // acc: Booth accumulator / division partial remainder (W+1 bits).
    // q:   Booth multiplier / dividend shifting into the quotient.
    // m:   sign-extended multiplicand / zero-extended divisor magnitude.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH:0]   m;
    logic             neg_q;
    logic             neg_r;

    // Operand magnitudes. A WIDTH-bit unsigned magnitude already holds
    // 2^(WIDTH-1), so |most-negative| needs no extra bit here.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // One Booth step: add/sub, then arithmetic shift right across acc:q:q_m1.
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc_nx;
    logic [WIDTH-1:0] booth_q_nx;

    // One restoring-division step.
    logic [WIDTH:0]   r_sh;
    logic             div_ge;
    logic [WIDTH:0]   div_rem_nx;

    always_comb begin
        a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
        b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m;
            2'b10:   booth_sum = acc - m;
            default: booth_sum = acc;
        endcase
        booth_acc_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_q_nx   = {booth_sum[0], q[WIDTH-1:1]};

        // The partial remainder stays below the divisor magnitude, which is
        // at most 2^(WIDTH-1), so the shifted value fits in WIDTH+1 bits.
        r_sh       = {acc[WIDTH-1:0], q[WIDTH-1]};
        div_ge     = (r_sh >= m);
        div_rem_nx = div_ge ? (r_sh - m) : r_sh;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_r  <= 1'b0;
            acc   <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            m     <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op && (b == '0)) begin
                            state <= S_DZ;
                        end else begin
                            state <= S_CALC;
                            cnt   <= '0;
                            op_r  <= op;
                            acc   <= '0;
                            q_m1  <= 1'b0;
                            if (!op) begin
                                q     <= b;
                                m     <= {a[WIDTH-1], a};
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                            end else begin
                                q     <= a_mag;
                                m     <= {1'b0, b_mag};
                                neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                                neg_r <= a[WIDTH-1];
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (!op_r) begin
                        acc  <= booth_acc_nx;
                        q    <= booth_q_nx;
                        q_m1 <= q[0];
                    end else begin
                        acc <= div_rem_nx;
                        q   <= {q[WIDTH-2:0], div_ge};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Booth leaves the product as acc[W-1:0]:q. Division
                    // leaves remainder in acc and quotient in q, both as
                    // magnitudes that still need their signs restored.
                    if (!op_r) begin
                        hi <= acc[WIDTH-1:0];
                        lo <= q;
                    end else begin
                        hi <= neg_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
                        lo <= neg_q ? (~q + 1'b1) : q;
                    end
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                S_DZ:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign load_hi   = (state == S_DONE);
    assign load_lo   = (state == S_DONE);
    assign div_zero  = (state == S_DZ);
    assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed cases with literal results, then randomized traffic, checked
//   every cycle against an arithmetic model of the sequencer.
module tb_muldiv_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 2;  // busy cycles for an accepted MULT/DIV

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero, load_hi, load_lo;
    logic [W-1:0] hi, lo;
    logic [2:0]   state_dbg;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero),
        .load_hi(load_hi), .load_lo(load_lo), .hi(hi), .lo(lo),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int n_done = 0;
    int n_dz   = 0;
    int n_busy = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic void ref_calc(input bit o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] h, output logic [W-1:0] l);
        longint sx;
        longint sy;
        longint p;
        longint qv;
        longint rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p = sx * sy;
            h = p[63:32];
            l = p[31:0];
        end else begin
            qv = sx / sy;  // truncates toward zero
            rv = sx % sy;  // sign of dividend
            h = rv[31:0];
            l = qv[31:0];
        end
    endfunction

    // ---------------- behavioural model ----------------
    // rem = cycles of busy still to come; a job's results appear in hi/lo
    // at the start of its last busy cycle, together with done.
    int           m_rem = 0;
    bit           m_dz = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [W-1:0] p_hi = '0, p_lo = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem = 0;
            m_dz  = 1'b0;
            m_hi  = '0;
            m_lo  = '0;
        end else if (m_rem == 0) begin
            if (start) begin
                if (op && b == '0) begin
                    m_dz  = 1'b1;
                    m_rem = 1;
                end else begin
                    m_dz  = 1'b0;
                    m_rem = LAT;
                    ref_calc(op, a, b, p_hi, p_lo);
                end
            end
        end else begin
            m_rem--;
            if (m_rem == 1 && !m_dz) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (done) n_done++;
        if (div_zero) n_dz++;
        if (busy) n_busy++;
        if (chk_en) begin
            chk("busy",     {31'b0, busy},     {31'b0, m_rem != 0});
            chk("done",     {31'b0, done},     {31'b0, m_rem == 1 && !m_dz});
            chk("load_hi",  {31'b0, load_hi},  {31'b0, m_rem == 1 && !m_dz});
            chk("load_lo",  {31'b0, load_lo},  {31'b0, m_rem == 1 && !m_dz});
            chk("div_zero", {31'b0, div_zero}, {31'b0, m_rem == 1 && m_dz});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input bit o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Run one op to completion and check hi/lo against literal values.
    task automatic run_op(input string name, input bit o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        int d0;
        d0 = n_done;
        pulse_start(o, x, y);
        repeat (LAT + 2) @(negedge clk);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        chk({name, "_done_cnt"}, W'(n_done - d0), W'(1));
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int b0, d0, z0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, '0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        reset = 1'b0;
        chk_en = 1'b1;

        b0 = n_busy;
        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        chk("mul_busy_len", W'(n_busy - b0), W'(LAT));
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);

        // Divide by zero: one div_zero pulse, no done, hi/lo unchanged.
        d0 = n_done;
        z0 = n_dz;
        pulse_start(1'b1, 32'd100, 32'd0);
        repeat (3) @(negedge clk);
        chk("dz_pulse_cnt", W'(n_dz - z0), W'(1));
        chk("dz_done_cnt", W'(n_done - d0), W'(0));
        chk("dz_hi_hold", hi, 32'h1);
        chk("dz_lo_hold", lo, 32'hFFFF_FFFD);

        // Overflow divide with a second start while busy.
        d0 = n_done;
        pulse_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT) @(negedge clk);
        chk("div_ovf_hi", hi, 32'h0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_done_cnt", W'(n_done - d0), W'(1));

        // Asynchronous reset mid-operation.
        d0 = n_done;
        pulse_start(1'b0, 32'd1234, 32'd5678);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, '0);
        chk("arst_hi", hi, '0);
        chk("arst_lo", lo, '0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        chk("arst_no_done", W'(n_done - d0), W'(0));
        run_op("mul_after_rst", 1'b0, 32'd3, 32'd5, 32'h0, 32'd15);

        // Randomized traffic, including starts while busy and b == 0.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 1);
            a = rnd_val();
            b = rnd_val();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
